ring_traffic_gen: RTL and testbench

Per-node packet source for the ring NoC. It generates open-loop traffic at a fixed injection rate, up to a fixed packet count, using a selectable destination pattern. Each packet is stamped with its generation cycle. Packets are buffered in a small source queue and presented to the ring node's injection port over a valid/ready handshake. One instance sits directly upstream of each ring node's local input.

---
 rtl/ring_traffic_gen.sv | 168 ++++++++++++++++
 tb/tb_ring_traffic_gen.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ring_traffic_gen.sv
`default_nettype none
// ring_traffic_gen: open-loop per-node packet source with a timestamped source queue
// feeding a ring node's injection port over valid/ready.  Revision 1.0
module ring_traffic_gen #(
  parameter int          NUM_NODES            = 4,
  parameter int          NODE_ID              = 0,
  parameter int          PACKET_SIZE          = 49,
  parameter int          INJECT_CYCLE         = 2,
  parameter int          NUM_PACKETS_PER_NODE = 20,
  parameter int          TRAFFIC_PATTERN      = 0,
  parameter int          QUEUE_DEPTH          = 4,
  parameter logic [15:0] LFSR_SEED            = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  output logic [PACKET_SIZE-1:0] out_pkt,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [15:0]            injected_count,
  output logic [15:0]            stall_cycles,
  output logic                   done
);

  localparam int          AW       = $clog2(QUEUE_DEPTH);
  localparam logic [AW:0] C_DEPTH  = (AW+1)'(QUEUE_DEPTH);
  localparam logic [AW:0] C_ONE    = (AW+1)'(1);
  localparam logic [15:0] C_NODE   = 16'(NODE_ID);
  localparam logic [15:0] C_MASK   = 16'(NUM_NODES - 1);
  localparam logic [15:0] C_RELOAD = 16'(INJECT_CYCLE - 1);
  localparam logic [15:0] C_NPKT   = 16'(NUM_PACKETS_PER_NODE);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]             r_state;
  logic [15:0]            r_cycle_cnt;
  logic [15:0]            r_timer;
  logic [15:0]            r_gen_count;
  logic [15:0]            r_lfsr;
  logic [PACKET_SIZE-1:0] r_mem [QUEUE_DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [AW:0]            r_count;
  logic [15:0]            r_injected;
  logic [15:0]            r_stall;
  logic                   r_done;

  logic                   w_empty;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_try;
  logic                   w_push;
  logic                   w_stall;
  logic                   w_lfsr_fb;
  logic [15:0]            w_lfsr_idx;
  logic [15:0]            w_dest;
  logic [PACKET_SIZE-1:0] w_pkt;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == C_DEPTH);
  assign w_pop   = !w_empty && out_ready;
  // A full queue still accepts when its head leaves in the same cycle.
  assign w_try   = (r_state == S_RUN) && enable && (r_timer == 16'd0);
  assign w_push  = w_try && (!w_full || w_pop);
  assign w_stall = w_try && !w_push;

  assign w_lfsr_fb  = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_lfsr_idx = r_lfsr & C_MASK;

  always_comb begin
    w_dest = (~C_NODE) & C_MASK;
    case (TRAFFIC_PATTERN)
      1: w_dest = (C_NODE + 16'd1) & C_MASK;
      2: begin
        if (w_lfsr_idx == C_NODE) begin
          w_dest = (w_lfsr_idx + 16'd1) & C_MASK;
        end else begin
          w_dest = w_lfsr_idx;
        end
      end
      default: w_dest = (~C_NODE) & C_MASK;
    endcase
  end

  assign w_pkt = PACKET_SIZE'({1'b1, r_cycle_cnt, C_NODE, w_dest});

  assign out_valid      = !w_empty;
  assign out_pkt        = w_empty ? '0 : r_mem[r_rd_ptr];
  assign injected_count = r_injected;
  assign stall_cycles   = r_stall;
  assign done           = r_done;

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= w_pkt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cycle_cnt <= '0;
      r_timer     <= '0;
      r_gen_count <= '0;
      r_lfsr      <= LFSR_SEED;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_injected  <= '0;
      r_stall     <= '0;
      r_done      <= 1'b0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 16'd1;

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + AW'(1);
        r_injected <= r_injected + 16'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_ONE;
        2'b01:   r_count <= r_count - C_ONE;
        default: r_count <= r_count;
      endcase

      if (w_stall && (r_stall != 16'hFFFF)) begin
        r_stall <= r_stall + 16'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (enable) begin
            if (w_push) begin
              r_gen_count <= r_gen_count + 16'd1;
              r_timer     <= C_RELOAD;
              r_lfsr      <= {r_lfsr[14:0], w_lfsr_fb};
              if ((r_gen_count + 16'd1) == C_NPKT) begin
                r_state <= S_DRAIN;
              end
            end else if (r_timer != 16'd0) begin
              r_timer <= r_timer - 16'd1;
            end
          end
        end
        // Leave DRAIN as the last entry departs so done rises right after it.
        S_DRAIN: begin
          if (w_empty || (w_pop && (r_count == C_ONE))) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= r_state;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ring_traffic_gen.sv
`default_nettype none
`timescale 1ns/1ps
// tb_ring_traffic_gen: three generator instances (complement, neighbour, LFSR)
// checked against a cycle-level behavioural model through an expected-packet scoreboard.
module tb_ring_traffic_gen;

  localparam int NN  = 4;
  localparam int PS  = 49;
  localparam int INJ = 2;
  localparam int NP  = 20;
  localparam int QD  = 4;
  localparam int NI  = 3;
  localparam int SBN = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic out_ready = 1'b0;

  logic [PS-1:0] pkt [NI];
  logic          vld [NI];
  logic [15:0]   inj [NI];
  logic [15:0]   stl [NI];
  logic          dn  [NI];

  int nid [NI] = '{1, 3, 0};
  int pat [NI] = '{0, 1, 2};

  int n_cmp  = 0;
  int n_fail = 0;
  bit armed  = 1'b0;

  int          m_state [NI];
  int          m_timer [NI];
  int          m_gen   [NI];
  int          m_occ   [NI];
  logic [15:0] m_cyc   [NI];
  logic [15:0] m_lfsr  [NI];
  logic [15:0] m_inj   [NI];
  logic [15:0] m_stall [NI];

  logic [PS-1:0] sb_mem [NI][SBN];
  int            sb_wr  [NI];
  int            sb_rd  [NI];

  always #5 clk = ~clk;

  ring_traffic_gen #(.NUM_NODES(NN), .NODE_ID(1), .PACKET_SIZE(PS), .INJECT_CYCLE(INJ),
    .NUM_PACKETS_PER_NODE(NP), .TRAFFIC_PATTERN(0), .QUEUE_DEPTH(QD), .LFSR_SEED(16'hACE1))
  u_a (.clk(clk), .rst(rst), .enable(enable), .out_pkt(pkt[0]), .out_valid(vld[0]),
    .out_ready(out_ready), .injected_count(inj[0]), .stall_cycles(stl[0]), .done(dn[0]));

  ring_traffic_gen #(.NUM_NODES(NN), .NODE_ID(3), .PACKET_SIZE(PS), .INJECT_CYCLE(INJ),
    .NUM_PACKETS_PER_NODE(NP), .TRAFFIC_PATTERN(1), .QUEUE_DEPTH(QD), .LFSR_SEED(16'hACE1))
  u_b (.clk(clk), .rst(rst), .enable(enable), .out_pkt(pkt[1]), .out_valid(vld[1]),
    .out_ready(out_ready), .injected_count(inj[1]), .stall_cycles(stl[1]), .done(dn[1]));

  ring_traffic_gen #(.NUM_NODES(NN), .NODE_ID(0), .PACKET_SIZE(PS), .INJECT_CYCLE(INJ),
    .NUM_PACKETS_PER_NODE(NP), .TRAFFIC_PATTERN(2), .QUEUE_DEPTH(QD), .LFSR_SEED(16'hACE1))
  u_c (.clk(clk), .rst(rst), .enable(enable), .out_pkt(pkt[2]), .out_valid(vld[2]),
    .out_ready(out_ready), .injected_count(inj[2]), .stall_cycles(stl[2]), .done(dn[2]));

  task automatic check(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[inst %0d] @%0t: got %h, expected %h", name, k, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  function automatic logic [15:0] dest_of(input int k, input logic [15:0] lf);
    int v;
    case (pat[k])
      1:       v = (nid[k] + 1) % NN;
      2: begin
        v = int'(lf) % NN;
        if (v == nid[k]) v = (v + 1) % NN;
      end
      default: v = (NN - 1) - nid[k];
    endcase
    return 16'(v);
  endfunction

  // Reference model: advances one cycle just after each edge, using the inputs that edge saw.
  task automatic model_step(input int k);
    bit pop;
    bit push;
    logic [PS-1:0] p;
    if (rst) begin
      m_state[k] = 0; m_timer[k] = 0; m_gen[k] = 0; m_occ[k] = 0;
      m_cyc[k] = 16'd0; m_lfsr[k] = 16'hACE1; m_inj[k] = 16'd0; m_stall[k] = 16'd0;
      sb_wr[k] = 0; sb_rd[k] = 0;
      return;
    end
    pop  = (m_occ[k] > 0) && out_ready;
    push = 1'b0;
    p    = '0;
    case (m_state[k])
      0: if (enable) m_state[k] = 1;
      1: if (enable) begin
        if (m_timer[k] == 0) begin
          if (m_occ[k] < QD || pop) begin
            push = 1'b1;
            p = {1'b1, m_cyc[k], 16'(nid[k]), dest_of(k, m_lfsr[k])};
            m_lfsr[k] = lfsr_next(m_lfsr[k]);
            m_gen[k]++;
            m_timer[k] = INJ - 1;
            if (m_gen[k] == NP) m_state[k] = 2;
          end else if (m_stall[k] != 16'hFFFF) begin
            m_stall[k] = m_stall[k] + 16'd1;
          end
        end else begin
          m_timer[k]--;
        end
      end
      2: if (m_occ[k] - int'(pop) == 0) m_state[k] = 3;
      default: ;
    endcase
    if (pop) m_inj[k] = m_inj[k] + 16'd1;
    m_occ[k] = m_occ[k] + int'(push) - int'(pop);
    if (push) begin
      sb_mem[k][sb_wr[k] % SBN] = p;
      sb_wr[k]++;
    end
    m_cyc[k] = m_cyc[k] + 16'd1;
  endtask

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < NI; k++) model_step(k);
    if (rst) armed = 1'b1;
  end

  // Monitor: compares what each DUT presents against the scoreboard head and pops on acceptance.
  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < NI; k++) begin
        bit ev;
        ev = (sb_wr[k] != sb_rd[k]);
        check("out_valid", k, 64'(vld[k]), 64'(ev));
        if (ev) begin
          check("out_pkt", k, 64'(pkt[k]), 64'(sb_mem[k][sb_rd[k] % SBN]));
          if (vld[k] && out_ready) sb_rd[k]++;
        end else begin
          check("out_pkt_empty", k, 64'(pkt[k]), 64'd0);
        end
        if (pat[k] == 2 && vld[k]) begin
          check("lfsr_dest_not_self", k, 64'(pkt[k][15:0] != 16'(nid[k])), 64'd1);
        end
        check("done", k, 64'(dn[k]), 64'(m_state[k] == 3));
        check("injected_count", k, 64'(inj[k]), 64'(m_inj[k]));
        check("stall_cycles", k, 64'(stl[k]), 64'(m_stall[k]));
      end
    end
  end

  task automatic start_phase();
    rst = 1'b1; enable = 1'b0; out_ready = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  // mode 1: free run, 2: early backpressure, 3: enable gap, 4: mid-run reset, 5: random
  task automatic run(input int mode, input int ncyc);
    logic [PS-1:0] first_pkt;
    first_pkt = {1'b1, 16'd1, 16'd1, 16'd2};
    for (int c = 0; c < ncyc; c++) begin
      rst = 1'b0; enable = 1'b1; out_ready = 1'b1;
      case (mode)
        2: out_ready = (c >= 20);
        3: enable = !(c >= 5 && c <= 14);
        4: rst = (c == 10);
        5: begin
          enable    = ($urandom % 4) != 0;
          out_ready = ($urandom % 3) != 0;
        end
        default: ;
      endcase
      @(negedge clk); #1;
      if (mode == 1 && c == 1)  check("first_valid_low", 0, 64'(vld[0]), 64'd0);
      if (mode == 1 && c == 2)  check("first_pkt_c2", 0, 64'(pkt[0]), 64'(first_pkt));
      if (mode == 1 && c == 40) check("done_c40", 0, 64'(dn[0]), 64'd0);
      if (mode == 1 && c == 41) check("done_c41", 0, 64'(dn[0]), 64'd1);
      if (mode == 2 && c == 19) check("stall_c19", 0, 64'(stl[0]), 64'd10);
      if (mode == 3 && c == 12) check("drained_in_gap", 0, 64'(vld[0]), 64'd0);
      if (mode == 4 && c == 11) begin
        check("rst_valid", 0, 64'(vld[0]), 64'd0);
        check("rst_injected", 0, 64'(inj[0]), 64'd0);
        check("rst_done", 0, 64'(dn[0]), 64'd0);
      end
      if (mode == 4 && c == 13) check("rerun_first_pkt", 0, 64'(pkt[0]), 64'(first_pkt));
      @(posedge clk); #2;
    end
    for (int k = 0; k < NI; k++) begin
      check("final_done", k, 64'(dn[k]), 64'd1);
      check("final_injected", k, 64'(inj[k]), 64'(NP));
      if (mode == 1) check("final_stall_free", k, 64'(stl[k]), 64'd0);
      if (mode == 2) check("final_stall_bp", k, 64'(stl[k]), 64'd11);
    end
  endtask

  initial begin
    @(posedge clk); #2;
    start_phase(); run(1, 60);
    start_phase(); run(2, 70);
    start_phase(); run(3, 80);
    start_phase(); run(4, 75);
    for (int i = 0; i < 3; i++) begin
      start_phase(); run(5, 300);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
